// File: rtl/monitor_anel_4bits.sv
// Watches a 4-bit ring-counter pattern, counts legal single-bit rotations,
// reports direction and position, and latches an error on any illegal jump.
module monitor_anel_4bits (
  input  logic       ck,
  input  logic       clr,
  input  logic [3:0] a,
  output logic [1:0] pos,
  output logic       valido,
  output logic       passo,
  output logic       sentido,
  output logic [7:0] cont,
  output logic       erro,
  output logic [6:0] seg
);

  localparam logic [1:0] SINC    = 2'd0;
  localparam logic [1:0] TRAVADO = 2'd1;
  localparam logic [1:0] ERRO    = 2'd2;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  logic [3:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [3:0] ref_q, ref_d;
  logic [1:0] state_q, state_d;
  logic [1:0] pos_q, pos_d;
  logic       valido_q, valido_d;
  logic       passo_q, passo_d;
  logic       sentido_q, sentido_d;
  logic [7:0] cont_q, cont_d;
  logic       erro_q, erro_d;
  logic [6:0] seg_q, seg_d;

  logic [3:0] sample, rot_l, rot_r;
  logic       stable, hot;

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  always_comb begin
    s1_d      = a;
    s2_d      = s1_q;
    s3_d      = s2_q;
    ref_d     = ref_q;
    state_d   = state_q;
    pos_d     = pos_q;
    valido_d  = valido_q;
    passo_d   = 1'b0;
    sentido_d = sentido_q;
    cont_d    = cont_q;
    erro_d    = erro_q;

    // Only a sample that held across two synchronized cycles is trusted.
    sample = s2_q;
    stable = (s2_q == s3_q);
    hot    = (sample != 4'b0000) && ((sample & (sample - 4'd1)) == 4'b0000);
    rot_l  = {ref_q[2:0], ref_q[3]};
    rot_r  = {ref_q[0], ref_q[3:1]};

    if (stable) begin
      valido_d = hot;
      case (state_q)
        SINC: begin
          if (hot) begin
            ref_d   = sample;
            pos_d   = enc(sample);
            state_d = TRAVADO;
          end
        end
        TRAVADO: begin
          if (sample != ref_q) begin
            if (sample == rot_l || sample == rot_r) begin
              passo_d   = 1'b1;
              sentido_d = (sample == rot_l);
              cont_d    = cont_q + 8'd1;
              ref_d     = sample;
              pos_d     = enc(sample);
            end else begin
              erro_d  = 1'b1;
              state_d = ERRO;
            end
          end
        end
        default: ;
      endcase
    end

    // Display follows the next state so it changes on the same edge.
    case (state_d)
      TRAVADO: begin
        case (pos_d)
          2'd0:    seg_d = 7'b1000000;
          2'd1:    seg_d = 7'b1111001;
          2'd2:    seg_d = 7'b0100100;
          default: seg_d = 7'b0110000;
        endcase
      end
      ERRO:    seg_d = SEG_E;
      default: seg_d = SEG_DASH;
    endcase
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      s1_q      <= 4'b0000;
      s2_q      <= 4'b0000;
      s3_q      <= 4'b0000;
      ref_q     <= 4'b0001;
      state_q   <= SINC;
      pos_q     <= 2'd0;
      valido_q  <= 1'b0;
      passo_q   <= 1'b0;
      sentido_q <= 1'b0;
      cont_q    <= 8'd0;
      erro_q    <= 1'b0;
      seg_q     <= SEG_DASH;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      ref_q     <= ref_d;
      state_q   <= state_d;
      pos_q     <= pos_d;
      valido_q  <= valido_d;
      passo_q   <= passo_d;
      sentido_q <= sentido_d;
      cont_q    <= cont_d;
      erro_q    <= erro_d;
      seg_q     <= seg_d;
    end
  end

  assign pos     = pos_q;
  assign valido  = valido_q;
  assign passo   = passo_q;
  assign sentido = sentido_q;
  assign cont    = cont_q;
  assign erro    = erro_q;
  assign seg     = seg_q;

endmodule
